// File: rtl/host_cycle_seq.sv
//------------------------------------------------------------------------------
// host_cycle_seq : runs one host bus cycle (2MHz, or stretched 1MHz) per CPU request
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module host_cycle_seq #(
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT     = 255,
   parameter int TW          = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic host_req,
   input  logic host_rnw,
   input  logic slow,
   input  logic bbc_phi0,
   output logic lat_en,
   output logic bbc_cyc,
   output logic bbc_rnw,
   output logic data_cap,
   output logic cpu_ack,
   output logic err,
   output logic busy
);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_WAIT_RISE = 2'd1,
      S_DATA      = 2'd2,
      S_DONE      = 2'd3
   } state_t;

   localparam logic [TW-1:0] c_timeout = TW'(TIMEOUT);
   localparam logic [TW-1:0] c_tmax    = '1;
   localparam logic [TW-1:0] c_one     = TW'(1);

   state_t                 r_state;
   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_hist;
   logic                   r_e_ph;
   logic                   r_slow;
   logic                   r_err_pend;
   logic [1:0]             r_fall_cnt;
   logic [TW-1:0]          r_timer;

   logic          w_rise;
   logic          w_fall;
   logic          w_go_data;
   logic          w_last_fall;
   logic          w_timeout;
   logic [TW-1:0] w_timer_inc;

   // Synchroniser and history flop carry no reset so a reset never fakes an edge.
   always_ff @(posedge clk) begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], bbc_phi0};
      r_hist <= r_sync[SYNC_STAGES-1];
   end

   assign w_rise = r_sync[SYNC_STAGES-1] & ~r_hist;
   assign w_fall = ~r_sync[SYNC_STAGES-1] & r_hist;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_e_ph <= 1'b0;
      end else if (w_rise) begin
         r_e_ph <= ~r_e_ph;
      end
   end

   // A slow cycle only starts on the rise that opens the second half of the 1MHz period.
   assign w_go_data   = w_rise && (!r_slow || r_e_ph);
   assign w_last_fall = w_fall && (r_fall_cnt == (r_slow ? 2'd1 : 2'd0));
   assign w_timeout   = (r_timer == c_timeout);
   assign w_timer_inc = (r_timer == c_tmax) ? r_timer : r_timer + c_one;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_slow     <= 1'b0;
         r_err_pend <= 1'b0;
         r_fall_cnt <= 2'd0;
         r_timer    <= '0;
         lat_en     <= 1'b0;
         bbc_cyc    <= 1'b0;
         bbc_rnw    <= 1'b0;
         data_cap   <= 1'b0;
         cpu_ack    <= 1'b0;
         err        <= 1'b0;
         busy       <= 1'b0;
      end else begin
         data_cap <= 1'b0;
         cpu_ack  <= 1'b0;
         err      <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (host_req) begin
                  bbc_rnw    <= host_rnw;
                  r_slow     <= slow;
                  r_timer    <= '0;
                  r_fall_cnt <= 2'd0;
                  r_err_pend <= 1'b0;
                  lat_en     <= 1'b1;
                  busy       <= 1'b1;
                  r_state    <= S_WAIT_RISE;
               end
            end

            S_WAIT_RISE: begin
               if (w_go_data) begin
                  bbc_cyc <= 1'b1;
                  r_timer <= '0;
                  r_state <= S_DATA;
               end else if (w_timeout) begin
                  r_err_pend <= 1'b1;
                  lat_en     <= 1'b0;
                  r_timer    <= '0;
                  r_state    <= S_DONE;
               end else begin
                  r_timer <= w_timer_inc;
               end
            end

            S_DATA: begin
               // The qualifying fall wins over a timeout landing in the same clock.
               if (w_last_fall) begin
                  r_fall_cnt <= r_fall_cnt + 2'd1;
                  data_cap   <= bbc_rnw;
                  bbc_cyc    <= 1'b0;
                  lat_en     <= 1'b0;
                  r_timer    <= '0;
                  r_state    <= S_DONE;
               end else if (w_timeout) begin
                  r_err_pend <= 1'b1;
                  bbc_cyc    <= 1'b0;
                  lat_en     <= 1'b0;
                  r_timer    <= '0;
                  r_state    <= S_DONE;
               end else begin
                  if (w_fall) begin
                     r_fall_cnt <= r_fall_cnt + 2'd1;
                  end
                  r_timer <= w_timer_inc;
               end
            end

            S_DONE: begin
               cpu_ack    <= 1'b1;
               err        <= r_err_pend;
               r_err_pend <= 1'b0;
               busy       <= 1'b0;
               r_state    <= S_IDLE;
            end

            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

`default_nettype wire
